// File: rtl/vga_stream_gen.sv
// Head of the VGA text-overlay pipeline: 800x600@72 timing, background fill,
// and a once-per-frame snapshot of a register value for tear-free display.
module vga_stream_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FRONT  = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BACK   = 64,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FRONT  = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BACK   = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic [2:0]  bg_i,
  input  logic [15:0] reg_i,
  output logic [25:0] strRGB_o,
  output logic [15:0] reg_o,
  output logic        frame_tick_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [25:0] str_q, str_d;
  logic [15:0] reg_q, reg_d;
  logic        tick_q, tick_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        active, hs_on, vs_on, frame_start;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    active      = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    hs_on       = (h_q >= HS_START) && (h_q < HS_END);
    vs_on       = (v_q >= VS_START) && (v_q < VS_END);
    frame_start = (h_q == '0) && (v_q == '0);

    // XC deliberately keeps only h[9:0]; blanking columns alias but are never drawn.
    str_d = {active ? bg_i : 3'b000, h_q[9:0], v_q,
             hs_on ? HS_POL : ~HS_POL, vs_on ? VS_POL : ~VS_POL, active};

    tick_d = frame_start;
    cnt_d  = frame_start ? cnt_q + 8'd1 : cnt_q;
    reg_d  = ((h_q == '0) && (v_q == V_ACT_END)) ? reg_i : reg_q;
  end

  // NOTE: state updates use <= only; all next-state logic lives in the always_comb
  // above so every flop has exactly one driver and no latch can be inferred.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q    <= '0;
      v_q    <= '0;
      str_q  <= '0;
      reg_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      str_q  <= str_d;
      reg_q  <= reg_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
    end
  end

  assign strRGB_o     = str_q;
  assign reg_o        = reg_q;
  assign frame_tick_o = tick_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_vga_stream_gen.sv
// Bench for vga_stream_gen using a shrunken timing so several frames fit in a short run;
// a second instance exercises active-low sync polarity.
module tb_vga_stream_gen;

  localparam int HA = 20, HF = 3, HS_W = 4, HB = 5;
  localparam int VA = 10, VF = 2, VS_W = 2, VB = 3;
  localparam int HT = HA + HF + HS_W + HB;   // 32
  localparam int VT = VA + VF + VS_W + VB;   // 17
  localparam int FT = HT * VT;               // 544

  logic        px_clk;
  logic        reset_n;
  logic [2:0]  bg_i;
  logic [15:0] reg_i;
  logic [25:0] str_p, str_n;
  logic [15:0] reg_p, reg_n;
  logic        tick_p, tick_n;
  logic [7:0]  cnt_p, cnt_n;

  vga_stream_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS_W), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS_W), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .px_clk(px_clk), .reset_n(reset_n), .bg_i(bg_i), .reg_i(reg_i),
    .strRGB_o(str_p), .reg_o(reg_p), .frame_tick_o(tick_p), .frame_cnt_o(cnt_p)
  );

  vga_stream_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS_W), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS_W), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_n (
    .px_clk(px_clk), .reset_n(reset_n), .bg_i(bg_i), .reg_i(reg_i),
    .strRGB_o(str_n), .reg_o(reg_n), .frame_tick_o(tick_n), .frame_cnt_o(cnt_n)
  );

  initial begin
    px_clk = 1'b0;
    forever #5 px_clk = ~px_clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference state: k = rising edges since reset release.
  int          k;
  logic [25:0] exp_str;
  logic        exp_tick;
  logic [7:0]  exp_cnt;
  logic [15:0] exp_reg;
  int          last_tick;
  int          n_act, n_hs, n_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
  endtask

  // Frame position of the counters before edge k gives every output field directly.
  task automatic model_step();
    int p, h, v;
    bit act, hs, vs;
    k++;
    p   = (k - 1) % FT;
    h   = p % HT;
    v   = p / HT;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HF) && (h < HA + HF + HS_W);
    vs  = (v >= VA + VF) && (v < VA + VF + VS_W);
    exp_str  = {act ? bg_i : 3'b000, 10'(h), 10'(v), hs, vs, act};
    exp_tick = (p == 0);
    exp_cnt  = 8'((k - 1) / FT + 1);
    if (p == VA * HT) exp_reg = reg_i;
  endtask

  task automatic compare();
    check("str",    str_p,  exp_str);
    check("tick",   tick_p, exp_tick);
    check("cnt",    cnt_p,  exp_cnt);
    check("reg",    reg_p,  exp_reg);
    check("str_n",  str_n,  exp_str ^ 26'h0000006);
    check("tick_n", tick_n, exp_tick);
    check("cnt_n",  cnt_n,  exp_cnt);
    check("reg_n",  reg_n,  exp_reg);
    if (tick_p) begin
      if (last_tick > 0) check("tick_period", k - last_tick, FT);
      last_tick = k;
    end
    if (k <= FT) begin
      n_act += int'(str_p[0]);
      n_vs  += int'(str_p[1]);
      n_hs  += int'(str_p[2]);
    end
  endtask

  task automatic run(input int n, input bit rnd_bg, input bit rnd_reg);
    for (int i = 0; i < n; i++) begin
      @(posedge px_clk);
      model_step();
      @(negedge px_clk);
      compare();
      if (rnd_bg)  bg_i  = 3'($urandom_range(0, 7));
      if (rnd_reg) reg_i = 16'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_str"},   str_p,  26'd0);
    check({tag, "_reg"},   reg_p,  16'd0);
    check({tag, "_tick"},  tick_p, 1'b0);
    check({tag, "_cnt"},   cnt_p,  8'd0);
    check({tag, "_str_n"}, str_n,  26'd0);
    check({tag, "_cnt_n"}, cnt_n,  8'd0);
  endtask

  task automatic restart_model();
    k = 0; exp_reg = '0; last_tick = 0;
    n_act = 0; n_hs = 0; n_vs = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    bg_i    = 3'b001;
    reg_i   = 16'hBEEF;
    restart_model();
    #3;
    check_zero("rst0");
    @(negedge px_clk);
    reset_n = 1'b1;

    run(1, 1'b0, 1'b0);
    check("first_str",  str_p,  26'h0800001);
    check("first_tick", tick_p, 1'b1);
    check("first_cnt",  cnt_p,  8'd1);
    run(1, 1'b0, 1'b0);
    check("second_str",  str_p,  26'h0802001);
    check("second_tick", tick_p, 1'b0);

    run(318, 1'b1, 1'b0);
    check("reg_before_snap0", reg_p, 16'h0000);
    run(1, 1'b1, 1'b0);
    check("reg_after_snap0", reg_p, 16'hBEEF);
    run(263, 1'b1, 1'b0);
    reg_i = 16'h1234;
    run(280, 1'b1, 1'b0);
    check("reg_before_snap1", reg_p, 16'hBEEF);
    run(1, 1'b1, 1'b0);
    check("reg_after_snap1", reg_p, 16'h1234);
    check("cnt_frame1", cnt_p, 8'd2);
    check("active_per_frame", n_act, 200);
    check("hs_per_frame",     n_hs,  68);
    check("vs_per_frame",     n_vs,  64);

    run(224, 1'b1, 1'b0);
    check("tick_frame2", tick_p, 1'b1);
    check("cnt_frame2",  cnt_p,  8'd3);

    run(600, 1'b1, 1'b1);
    run((5 * HT + 10 - (k % FT) + FT) % FT, 1'b1, 1'b1);

    // Mid-frame reset between clock edges must clear everything at once.
    #2 reset_n = 1'b0;
    #1 check_zero("rst_async");
    @(posedge px_clk);
    @(negedge px_clk);
    check_zero("rst_hold");
    restart_model();
    bg_i = 3'b001;
    reset_n = 1'b1;
    run(1, 1'b0, 1'b0);
    check("restart_str", str_p, 26'h0800001);
    check("restart_cnt", cnt_p, 8'd1);
    run(700, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
